// File: rtl/res_station.sv
// Reservation station: holds renamed uops, snoops the CDB for operands, issues lowest-index ready slot.
// Latency: uop written with ready operands is presented on issue one edge later; registered outputs.
// Backpressure: issue register holds while issue_valid_out && !issue_ready_in; slots keep snooping.
package res_station_pkg;
    typedef logic [2:0] res_st_addr_t;
    typedef logic [3:0] rob_addr_t;

    typedef struct packed {
        logic [5:0]  op;
        rob_addr_t   qj;
        logic [31:0] vj;
        rob_addr_t   qk;
        logic [31:0] vk;
        logic [31:0] a;
        logic [31:0] pc;
        rob_addr_t   rob_addr;
        logic [4:0]  dest;
        logic        busy;
    } res_st_cell_t;
endpackage

module res_station
    import res_station_pkg::*;
#(
    parameter int DEPTH = 2**$bits(res_st_addr_t),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_in,
    input  logic         wr_en_in,
    input  res_st_addr_t wr_addr_in,
    input  res_st_cell_t wr_data_in,
    input  logic         cdb_valid_in,
    input  rob_addr_t    cdb_rob_addr_in,
    input  logic [31:0]  cdb_data_in,
    output logic         issue_valid_out,
    input  logic         issue_ready_in,
    output res_st_cell_t issue_data_out,
    output logic [CNT_W-1:0] count_out,
    output logic         full_out,
    output logic         overflow_err_out
);
    localparam int ADDR_W = $bits(res_st_addr_t);

    res_st_cell_t     slots [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             sel_vld;
    res_st_addr_t     sel_idx;
    logic             load;
    logic             do_issue;
    logic             wr_accept;
    logic             cdb_hit_j;
    logic             cdb_hit_k;
    res_st_cell_t     wr_cell;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = slots[i].busy && (slots[i].qj == '0) && (slots[i].qk == '0);
        end
    end

    // Walk downward so the last hit left standing is the lowest index.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                sel_vld = 1'b1;
                sel_idx = res_st_addr_t'(i);
            end
        end
    end

    assign load      = !issue_valid_out || issue_ready_in;
    assign do_issue  = load && sel_vld;
    assign wr_accept = wr_en_in && !slots[wr_addr_in].busy;

    // Tag 0 means "value present", so a broadcast on tag 0 must never match.
    assign cdb_hit_j = cdb_valid_in && (cdb_rob_addr_in != '0) && (wr_data_in.qj == cdb_rob_addr_in);
    assign cdb_hit_k = cdb_valid_in && (cdb_rob_addr_in != '0) && (wr_data_in.qk == cdb_rob_addr_in);

    always_comb begin
        wr_cell      = wr_data_in;
        wr_cell.busy = 1'b1;
        if (cdb_hit_j) begin
            wr_cell.qj = '0;
            wr_cell.vj = cdb_data_in;
        end
        if (cdb_hit_k) begin
            wr_cell.qk = '0;
            wr_cell.vk = cdb_data_in;
        end
    end

    always_comb begin
        count_nxt = count_out;
        if (wr_accept && !do_issue) begin
            count_nxt = count_out + CNT_W'(1);
        end else if (!wr_accept && do_issue) begin
            count_nxt = count_out - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            issue_valid_out  <= 1'b0;
            issue_data_out   <= '0;
            count_out        <= '0;
            full_out         <= 1'b0;
            overflow_err_out <= 1'b0;
        end else if (flush_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i].busy <= 1'b0;
            end
            issue_valid_out <= 1'b0;
            count_out       <= '0;
            full_out        <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slots[i].busy) begin
                    if (cdb_valid_in && (cdb_rob_addr_in != '0) && (slots[i].qj == cdb_rob_addr_in)) begin
                        slots[i].qj <= '0;
                        slots[i].vj <= cdb_data_in;
                    end
                    if (cdb_valid_in && (cdb_rob_addr_in != '0) && (slots[i].qk == cdb_rob_addr_in)) begin
                        slots[i].qk <= '0;
                        slots[i].vk <= cdb_data_in;
                    end
                    if (do_issue && (sel_idx == ADDR_W'(i))) begin
                        slots[i].busy <= 1'b0;
                    end
                end
            end
            // An accepted write only lands on a slot that was idle, so it never collides with the updates above.
            if (wr_accept) begin
                slots[wr_addr_in] <= wr_cell;
            end else if (wr_en_in) begin
                overflow_err_out <= 1'b1;
            end
            if (load) begin
                issue_valid_out <= sel_vld;
                if (sel_vld) begin
                    issue_data_out <= slots[sel_idx];
                end
            end
            count_out <= count_nxt;
            full_out  <= (count_nxt == CNT_W'(DEPTH));
        end
    end
endmodule

// File: tb/tb_res_station.sv
// Directed bench for res_station: issue latency, CDB wakeup/bypass, stall, full/overflow/flush, async reset.
module tb_res_station;
    import res_station_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush_in = 1'b0;
    logic         wr_en_in = 1'b0;
    res_st_addr_t wr_addr_in = '0;
    res_st_cell_t wr_data_in = '0;
    logic         cdb_valid_in = 1'b0;
    rob_addr_t    cdb_rob_addr_in = '0;
    logic [31:0]  cdb_data_in = '0;
    logic         issue_valid_out;
    logic         issue_ready_in = 1'b0;
    res_st_cell_t issue_data_out;
    logic [3:0]   count_out;
    logic         full_out;
    logic         overflow_err_out;

    int checks = 0;
    int failures = 0;

    res_station dut (
        .clk(clk), .rst(rst), .flush_in(flush_in),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .cdb_valid_in(cdb_valid_in), .cdb_rob_addr_in(cdb_rob_addr_in), .cdb_data_in(cdb_data_in),
        .issue_valid_out(issue_valid_out), .issue_ready_in(issue_ready_in), .issue_data_out(issue_data_out),
        .count_out(count_out), .full_out(full_out), .overflow_err_out(overflow_err_out)
    );

    always #5 clk = ~clk;

    function automatic res_st_cell_t mk(input rob_addr_t qj, input logic [31:0] vj,
                                        input rob_addr_t qk, input logic [31:0] vk,
                                        input rob_addr_t rob);
        res_st_cell_t c;
        c = '0;
        c.op = 6'h2A; c.qj = qj; c.vj = vj; c.qk = qk; c.vk = vk;
        c.rob_addr = rob; c.dest = 5'd9; c.pc = 32'h1000;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input res_st_addr_t addr, input res_st_cell_t c);
        wr_en_in = 1'b1; wr_addr_in = addr; wr_data_in = c;
    endtask

    task automatic idle();
        wr_en_in = 1'b0; cdb_valid_in = 1'b0; flush_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        chk("rst_valid", 32'(issue_valid_out), 0);
        chk("rst_count", 32'(count_out), 0);
        chk("rst_full", 32'(full_out), 0);
        chk("rst_ovf", 32'(overflow_err_out), 0);
        chk("rst_data_rob", 32'(issue_data_out.rob_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_simple_issue();
        issue_ready_in = 1'b0;
        wr(3'd0, mk(4'd0, 32'd5, 4'd0, 32'd7, 4'd3));
        step();
        idle();
        chk("t1_count_after_wr", 32'(count_out), 1);
        chk("t1_valid_early", 32'(issue_valid_out), 0);
        step();
        chk("t1_valid", 32'(issue_valid_out), 1);
        chk("t1_vj", issue_data_out.vj, 5);
        chk("t1_vk", issue_data_out.vk, 7);
        chk("t1_rob", 32'(issue_data_out.rob_addr), 3);
        chk("t1_count_issued", 32'(count_out), 0);
        issue_ready_in = 1'b1;
        step();
        chk("t1_valid_drop", 32'(issue_valid_out), 0);
    endtask

    task automatic test_cdb_wakeup();
        wr(3'd1, mk(4'd4, 32'd0, 4'd0, 32'd1, 4'd5));
        step();
        idle();
        cdb_valid_in = 1'b1; cdb_rob_addr_in = 4'd9; cdb_data_in = 32'h55;
        step();
        chk("t2_tag9_no_issue", 32'(issue_valid_out), 0);
        cdb_rob_addr_in = 4'd4; cdb_data_in = 32'hDEAD;
        step();
        idle();
        chk("t2_not_yet", 32'(issue_valid_out), 0);
        step();
        chk("t2_valid", 32'(issue_valid_out), 1);
        chk("t2_vj", issue_data_out.vj, 32'hDEAD);
        chk("t2_qj", 32'(issue_data_out.qj), 0);
        chk("t2_rob", 32'(issue_data_out.rob_addr), 5);
        step();
        chk("t2_drained", 32'(issue_valid_out), 0);
    endtask

    task automatic test_bypass();
        wr(3'd2, mk(4'd6, 32'd0, 4'd6, 32'd0, 4'd8));
        cdb_valid_in = 1'b1; cdb_rob_addr_in = 4'd6; cdb_data_in = 32'h11;
        step();
        idle();
        step();
        chk("t3_valid", 32'(issue_valid_out), 1);
        chk("t3_vj", issue_data_out.vj, 32'h11);
        chk("t3_vk", issue_data_out.vk, 32'h11);
        chk("t3_qk", 32'(issue_data_out.qk), 0);
        step();
        chk("t3_drained", 32'(issue_valid_out), 0);
    endtask

    task automatic test_back_to_back();
        issue_ready_in = 1'b0;
        wr(3'd2, mk(4'd0, 32'h222, 4'd0, 32'd0, 4'd2));
        step();
        wr(3'd5, mk(4'd0, 32'h555, 4'd0, 32'd0, 4'd10));
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall_valid", 32'(issue_valid_out), 1);
            chk("t4_stall_vj", issue_data_out.vj, 32'h222);
            step();
        end
        chk("t4_count_stalled", 32'(count_out), 1);
        issue_ready_in = 1'b1;
        step();
        chk("t4_next_valid", 32'(issue_valid_out), 1);
        chk("t4_next_vj", issue_data_out.vj, 32'h555);
        chk("t4_next_rob", 32'(issue_data_out.rob_addr), 10);
        chk("t4_count_zero", 32'(count_out), 0);
        step();
        chk("t4_drained", 32'(issue_valid_out), 0);
    endtask

    task automatic test_full_overflow_flush();
        chk("t5_ovf_before", 32'(overflow_err_out), 0);
        for (int i = 0; i < 8; i++) begin
            wr(res_st_addr_t'(i), mk(4'd7, 32'd0, 4'd0, 32'd0, 4'(i + 1)));
            step();
        end
        idle();
        chk("t5_count_full", 32'(count_out), 8);
        chk("t5_full", 32'(full_out), 1);
        chk("t5_no_issue", 32'(issue_valid_out), 0);
        wr(3'd0, mk(4'd0, 32'd1, 4'd0, 32'd1, 4'd12));
        step();
        idle();
        chk("t5_ovf", 32'(overflow_err_out), 1);
        chk("t5_count_after_drop", 32'(count_out), 8);
        step();
        chk("t5_dropped_no_issue", 32'(issue_valid_out), 0);
        flush_in = 1'b1;
        step();
        idle();
        chk("t5_flush_count", 32'(count_out), 0);
        chk("t5_flush_full", 32'(full_out), 0);
        chk("t5_ovf_sticky", 32'(overflow_err_out), 1);
        cdb_valid_in = 1'b1; cdb_rob_addr_in = 4'd7; cdb_data_in = 32'h77;
        step();
        idle();
        step();
        chk("t5_flushed_no_issue", 32'(issue_valid_out), 0);
    endtask

    task automatic test_async_reset();
        issue_ready_in = 1'b0;
        wr(3'd3, mk(4'd0, 32'h33, 4'd0, 32'h34, 4'd11));
        step();
        wr(3'd4, mk(4'd7, 32'd0, 4'd0, 32'd0, 4'd13));
        step();
        idle();
        chk("t6_pre_valid", 32'(issue_valid_out), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_valid_clear", 32'(issue_valid_out), 0);
        chk("t6_count_clear", 32'(count_out), 0);
        chk("t6_ovf_clear", 32'(overflow_err_out), 0);
        chk("t6_data_clear", issue_data_out.vj, 0);
        #2;
        rst = 1'b1;
        issue_ready_in = 1'b1;
        cdb_valid_in = 1'b1; cdb_rob_addr_in = 4'd7; cdb_data_in = 32'h99;
        step();
        idle();
        step();
        step();
        chk("t6_empty_valid", 32'(issue_valid_out), 0);
        chk("t6_empty_count", 32'(count_out), 0);
    endtask

    initial begin
        test_reset();
        test_simple_issue();
        test_cdb_wakeup();
        test_bypass();
        test_back_to_back();
        test_full_overflow_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
